// File: rtl/stopwatch_core.sv
// stopwatch_core: debounced start/stop/lap stopwatch keeping an H:M:S count advanced by a seconds strobe
module stopwatch_core #(
    parameter int DEBOUNCE_MS = 20,
    parameter int HOURS_WRAP  = 24
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick_1khz,
    input  logic       i_tick_1hz,
    input  logic       i_start_stop,
    input  logic       i_lap,
    output logic [5:0] o_seconds,
    output logic [5:0] o_minutes,
    output logic [4:0] o_hours,
    output logic       o_running,
    output logic       o_lap_active
);
    localparam int CW = $clog2(DEBOUNCE_MS);
    typedef enum logic [1:0] {IDLE, RUNNING, LAP_HOLD, PAUSED} state_t;
    state_t r_state, w_next;
    logic [1:0] w_btn, w_press;
    logic w_ss, w_lp, w_clear, w_en;
    logic [5:0] r_sec, r_min, r_disp_sec, r_disp_min;
    logic [4:0] r_hr, r_disp_hr;
    assign w_btn = {i_lap, i_start_stop};
    assign w_ss  = w_press[0];
    assign w_lp  = w_press[1];
    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_db
            logic r_s1, r_s2, r_stable, r_press;
            logic [CW-1:0] r_cnt;
            logic w_flip;
            // the DEBOUNCE_MS-th consecutive differing sample commits the new level
            assign w_flip = i_tick_1khz && (r_s2 != r_stable) && (r_cnt == CW'(DEBOUNCE_MS - 1));
            assign w_press[b] = r_press;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_stable <= 1'b0;
                    r_press  <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_s1    <= w_btn[b];
                    r_s2    <= r_s1;
                    r_press <= w_flip && r_s2;
                    if (i_tick_1khz) begin
                        r_cnt <= (r_s2 == r_stable || w_flip) ? '0 : r_cnt + 1'b1;
                        if (w_flip) r_stable <= r_s2;
                    end
                end
            end
        end
    endgenerate
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // StartStop takes priority over a coincident Lap press in every state
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            IDLE:     w_next = w_ss ? RUNNING : IDLE;
            RUNNING:  w_next = w_ss ? PAUSED : (w_lp ? LAP_HOLD : RUNNING);
            LAP_HOLD: w_next = w_ss ? PAUSED : (w_lp ? RUNNING : LAP_HOLD);
            PAUSED: begin
                w_next  = w_ss ? RUNNING : (w_lp ? IDLE : PAUSED);
                w_clear = !w_ss && w_lp;
            end
            default:  w_next = IDLE;
        endcase
    end
    assign w_en = (r_state == RUNNING) || (r_state == LAP_HOLD);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sec <= '0;
            r_min <= '0;
            r_hr  <= '0;
        end else if (w_clear) begin
            r_sec <= '0;
            r_min <= '0;
            r_hr  <= '0;
        end else if (w_en && i_tick_1hz) begin
            r_sec <= (r_sec == 6'd59) ? '0 : r_sec + 1'b1;
            if (r_sec == 6'd59) begin
                r_min <= (r_min == 6'd59) ? '0 : r_min + 1'b1;
                if (r_min == 6'd59) r_hr <= (r_hr == 5'(HOURS_WRAP - 1)) ? '0 : r_hr + 1'b1;
            end
        end
    end
    // display freezes while in LAP_HOLD, holding the value captured on the lap press edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_disp_sec <= '0;
            r_disp_min <= '0;
            r_disp_hr  <= '0;
        end else if (r_state != LAP_HOLD) begin
            r_disp_sec <= r_sec;
            r_disp_min <= r_min;
            r_disp_hr  <= r_hr;
        end
    end
    assign o_seconds    = r_disp_sec;
    assign o_minutes    = r_disp_min;
    assign o_hours      = r_disp_hr;
    assign o_running    = w_en;
    assign o_lap_active = (r_state == LAP_HOLD);
endmodule
